// File: rtl/jpeg_enc_du_pingpong_pkg.sv
// Shared constants and types for the JPEG encoder data-unit store.
package jpeg_enc_pkg;

    localparam int unsigned JE_DU_SIZE = 64;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    localparam int unsigned ERR_OVF  = 0;
    localparam int unsigned ERR_UDF  = 1;
    localparam int unsigned ERR_ADDR = 2;

endpackage

// File: rtl/jpeg_enc_du_pingpong_sdp_ram.sv
// Simple dual-port RAM: one write port, registered read port whose output
// register is asynchronously reset; the array itself is not reset.
module jpeg_enc_sdp_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 384,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/jpeg_enc_du_pingpong.sv
// Double-buffered data-unit store between colour conversion and DCT.
// Define JE_DU_PINGPONG_OUTREG_EN to add an output register (2-cycle read latency).
module jpeg_enc_du_pingpong
    import jpeg_enc_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CHANNELS = 3,
    localparam int unsigned AW      = $clog2(CHANNELS * JE_DU_SIZE)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_commit,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    input  logic              rd_release,
    output logic              rd_avail,
    output logic [1:0]        occupancy,
    output logic [2:0]        err_flags,
    input  logic              err_clr
);

    localparam int unsigned    BANK_D   = CHANNELS * JE_DU_SIZE;
    localparam int unsigned    PAW      = AW + 1;
    localparam logic [PAW-1:0] BANK_D_P = PAW'(BANK_D);

    occ_t              occ_q, occ_d;
    logic              wr_ptr, rd_ptr;
    logic              rd_valid_q;
    logic [2:0]        err_q, err_ev;
    logic              wr_addr_ok, rd_addr_ok;
    logic              wr_do, rd_do, commit_ok, release_ok;
    logic [PAW-1:0]    ram_wr_addr, ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;

    assign wr_ready  = (occ_q != OCC_FULL);
    assign rd_avail  = (occ_q != OCC_EMPTY);
    assign occupancy = occ_q;
    assign err_flags = err_q;

    assign wr_addr_ok = ({1'b0, wr_addr} < BANK_D_P);
    assign rd_addr_ok = ({1'b0, rd_addr} < BANK_D_P);
    assign wr_do      = wr_en && wr_ready && wr_addr_ok;
    assign rd_do      = rd_en && rd_avail && rd_addr_ok;
    assign commit_ok  = wr_commit && wr_ready;
    assign release_ok = rd_release && rd_avail;

    // Bank select is an offset rather than a concatenation so a non-power-of-two
    // bank depth still packs both banks into exactly 2*BANK_D words.
    assign ram_wr_addr = {1'b0, wr_addr} + (wr_ptr ? BANK_D_P : '0);
    assign ram_rd_addr = {1'b0, rd_addr} + (rd_ptr ? BANK_D_P : '0);

    always_comb begin
        err_ev           = '0;
        err_ev[ERR_OVF]  = (wr_en || wr_commit) && !wr_ready;
        err_ev[ERR_UDF]  = (rd_en || rd_release) && !rd_avail;
        err_ev[ERR_ADDR] = (wr_en && !wr_addr_ok) || (rd_en && !rd_addr_ok);
    end

    always_comb begin
        occ_d = occ_q;
        case ({commit_ok, release_ok})
            2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
            2'b01:   occ_d = (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q      <= OCC_EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            err_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            if (commit_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (release_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            // A same-cycle error event survives the clear.
            err_q      <= (err_clr ? 3'b000 : err_q) | err_ev;
            rd_valid_q <= rd_do;
        end
    end

    jpeg_enc_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (2 * BANK_D)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_do),
        .wr_addr (ram_wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_do),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

`ifdef JE_DU_PINGPONG_OUTREG_EN
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q   <= '0;
            rd_valid_q2 <= 1'b0;
        end else begin
            rd_data_q   <= ram_rd_data;
            rd_valid_q2 <= rd_valid_q;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q2;
`else
    assign rd_data       = ram_rd_data;
    assign rd_data_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_jpeg_enc_du_pingpong.sv
// Self-checking bench for jpeg_enc_du_pingpong (3- and 6-channel instances).
module tb_jpeg_enc_du_pingpong;

`ifdef JE_DU_PINGPONG_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int BD = 192;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en, wr_commit, rd_en, rd_release, err_clr;
    logic [7:0] wr_addr, wr_data, rd_addr;
    logic       wr_ready, rd_avail, rd_data_valid;
    logic [7:0] rd_data;
    logic [1:0] occupancy;
    logic [2:0] err_flags;

    logic       wr_en6, wr_commit6, rd_en6, rd_release6, err_clr6;
    logic [8:0] wr_addr6, rd_addr6;
    logic [7:0] wr_data6, rd_data6;
    logic       wr_ready6, rd_avail6, rd_data_valid6;
    logic [1:0] occupancy6;
    logic [2:0] err_flags6;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jpeg_enc_du_pingpong dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
        .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .rd_release(rd_release), .rd_avail(rd_avail),
        .occupancy(occupancy), .err_flags(err_flags), .err_clr(err_clr)
    );

    jpeg_enc_du_pingpong #(.DATA_W(8), .CHANNELS(6)) dut6 (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6), .wr_commit(wr_commit6),
        .wr_ready(wr_ready6),
        .rd_en(rd_en6), .rd_addr(rd_addr6), .rd_data(rd_data6), .rd_data_valid(rd_data_valid6),
        .rd_release(rd_release6), .rd_avail(rd_avail6),
        .occupancy(occupancy6), .err_flags(err_flags6), .err_clr(err_clr6)
    );

    typedef struct {
        bit         com;
        bit         rel;
        bit         clr;
        logic [1:0] occ;
        logic [2:0] err;
    } vec_t;
    vec_t tbl[12];

    // Reference model state (per-bank arrays, integer occupancy)
    logic [7:0] m_mem   [2][BD];
    bit         m_known [2][BD];
    int         m_occ, m_wp, m_rp;
    logic [2:0] m_err;
    bit         m_v1, m_v2, m_k1, m_k2;
    logic [7:0] m_d1, m_d2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0; err_clr = 0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        wr_en6 = 0; wr_commit6 = 0; rd_en6 = 0; rd_release6 = 0; err_clr6 = 0;
        wr_addr6 = '0; wr_data6 = '0; rd_addr6 = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        tick();
    endtask

    task automatic chk_state(input string name, input int occ, input logic [2:0] err);
        chk({name, " occupancy"}, occupancy, occ);
        chk({name, " wr_ready"}, wr_ready, occ != 2);
        chk({name, " rd_avail"}, rd_avail, occ != 0);
        chk({name, " err_flags"}, err_flags, err);
    endtask

    task automatic fill(input bit inv);
        for (int i = 0; i < BD; i++) begin
            wr_en = 1; wr_addr = 8'(i);
            wr_data = inv ? ~8'(i) : 8'(i);
            tick();
        end
        wr_en = 0;
    endtask

    task automatic pulse(input bit com, input bit rel, input bit clr);
        wr_commit = com; rd_release = rel; err_clr = clr;
        tick();
        wr_commit = 0; rd_release = 0; err_clr = 0;
    endtask

    task automatic read_chk(input string name, input int a, input logic [7:0] exp);
        rd_en = 1; rd_addr = 8'(a);
        tick();
        rd_en = 0;
        for (int k = 1; k < LAT; k++) tick();
        chk({name, " valid"}, rd_data_valid, 1);
        chk(name, rd_data, exp);
    endtask

    task automatic model_reset();
        m_occ = 0; m_wp = 0; m_rp = 0; m_err = '0;
        m_v1 = 0; m_v2 = 0; m_k1 = 1; m_k2 = 1; m_d1 = '0; m_d2 = '0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < BD; i++) m_known[b][i] = 0;
    endtask

    task automatic model_step();
        bit         w_rdy, r_av, rv, rk, c_ok, r_ok;
        logic [2:0] ev;
        logic [7:0] rd;
        w_rdy = (m_occ < 2);
        r_av  = (m_occ > 0);
        ev = '0;
        if ((wr_en || wr_commit) && !w_rdy) ev[0] = 1;
        if ((rd_en || rd_release) && !r_av) ev[1] = 1;
        if ((wr_en && int'(wr_addr) >= BD) || (rd_en && int'(rd_addr) >= BD)) ev[2] = 1;
        rv = rd_en && r_av && int'(rd_addr) < BD;
        rd = '0; rk = 1;
        if (rv) begin
            rd = m_mem[m_rp][rd_addr];
            rk = m_known[m_rp][rd_addr];
        end
        if (wr_en && w_rdy && int'(wr_addr) < BD) begin
            m_mem[m_wp][wr_addr]   = wr_data;
            m_known[m_wp][wr_addr] = 1;
        end
        m_err = (err_clr ? 3'b000 : m_err) | ev;
        c_ok = wr_commit && w_rdy;
        r_ok = rd_release && r_av;
        m_occ = m_occ + int'(c_ok) - int'(r_ok);
        if (c_ok) m_wp = 1 - m_wp;
        if (r_ok) m_rp = 1 - m_rp;
        m_v2 = m_v1; m_d2 = m_d1; m_k2 = m_k1;
        m_v1 = rv;
        if (rv) begin
            m_d1 = rd; m_k1 = rk;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{com:0, rel:1, clr:0, occ:0, err:3'b010};
        tbl[1]  = '{com:0, rel:0, clr:1, occ:0, err:3'b000};
        tbl[2]  = '{com:1, rel:0, clr:0, occ:1, err:3'b000};
        tbl[3]  = '{com:1, rel:0, clr:0, occ:2, err:3'b000};
        tbl[4]  = '{com:1, rel:0, clr:0, occ:2, err:3'b001};
        tbl[5]  = '{com:1, rel:1, clr:0, occ:1, err:3'b001};
        tbl[6]  = '{com:1, rel:1, clr:1, occ:1, err:3'b000};
        tbl[7]  = '{com:0, rel:1, clr:0, occ:0, err:3'b000};
        tbl[8]  = '{com:0, rel:1, clr:1, occ:0, err:3'b010};
        tbl[9]  = '{com:0, rel:0, clr:1, occ:0, err:3'b000};
        tbl[10] = '{com:1, rel:1, clr:0, occ:1, err:3'b010};
        tbl[11] = '{com:0, rel:0, clr:1, occ:1, err:3'b000};

        do_reset();
        chk_state("reset", 0, 3'b000);
        chk("reset rd_data", rd_data, 0);
        chk("reset rd_data_valid", rd_data_valid, 0);

        for (int i = 0; i < 12; i++) begin
            pulse(tbl[i].com, tbl[i].rel, tbl[i].clr);
            chk_state($sformatf("tbl%0d", i), int'(tbl[i].occ), tbl[i].err);
        end

        // Fill, commit, read back with latency
        do_reset();
        fill(0);
        pulse(1, 0, 0);
        chk_state("commit0", 1, 3'b000);
        read_chk("rd b0[5]", 5, 8'h05);
        tick();
        chk("valid drops", rd_data_valid, 0);
        chk("data holds", rd_data, 8'h05);

        // Two banks committed, overflow attempts
        fill(1);
        pulse(1, 0, 0);
        chk_state("full", 2, 3'b000);
        wr_en = 1; wr_addr = 8'd0; wr_data = 8'h55;
        pulse(1, 0, 0);
        wr_en = 0;
        chk_state("ovf", 2, 3'b001);
        read_chk("rd b0[7]", 7, 8'h07);

        // Release, then simultaneous commit+release at occupancy 1
        pulse(0, 1, 0);
        chk_state("rel1", 1, 3'b001);
        read_chk("rd b1[0]", 0, 8'hFF);
        pulse(1, 1, 0);
        chk_state("com+rel", 1, 3'b001);
        read_chk("rd b0[0] no ovf write", 0, 8'h00);

        // Underflow on empty release leaves rd_ptr alone
        pulse(0, 0, 1);
        chk_state("clr", 1, 3'b000);
        pulse(0, 1, 0);
        chk_state("rel empty", 0, 3'b000);
        pulse(0, 1, 0);
        chk_state("udf", 0, 3'b010);
        pulse(1, 0, 0);
        read_chk("rd b1[3] rp kept", 3, 8'hFC);

        // Out-of-range write must not reach the other bank
        wr_en = 1; wr_addr = 8'd192; wr_data = 8'hA5;
        tick();
        wr_en = 0;
        chk_state("addr err", 1, 3'b110);
        read_chk("rd b1[0] untouched", 0, 8'hFF);
        pulse(0, 0, 1);
        chk_state("clr2", 1, 3'b000);

        // Asynchronous reset mid-fill with both banks committed
        pulse(1, 0, 0);
        chk_state("full2", 2, 3'b000);
        read_chk("rd b1[2]", 2, 8'hFD);
        wr_en = 1; wr_addr = 8'd10; wr_data = 8'h33;
        rd_en = 1; rd_addr = 8'd4;
        tick();
        reset_n = 0;
        #1;
        chk_state("async rst", 0, 3'b000);
        chk("async rst rd_data", rd_data, 0);
        chk("async rst valid", rd_data_valid, 0);
        idle();
        tick();
        reset_n = 1;
        tick();

        // Six-channel instance: full 384-word bank
        for (int i = 0; i < 384; i++) begin
            wr_en6 = 1; wr_addr6 = 9'(i); wr_data6 = 8'(i * 7 + 3);
            tick();
        end
        wr_en6 = 0;
        wr_commit6 = 1;
        tick();
        wr_commit6 = 0;
        chk("ch6 occupancy", occupancy6, 1);
        for (int i = 0; i < 384; i++) begin
            rd_en6 = 1; rd_addr6 = 9'(i);
            tick();
            rd_en6 = 0;
            for (int k = 1; k < LAT; k++) tick();
            if (rd_data_valid6 !== 1'b1 || rd_data6 !== 8'(i * 7 + 3))
                chk($sformatf("ch6 rd[%0d]", i), {rd_data_valid6, rd_data6}, {1'b1, 8'(i * 7 + 3)});
        end
        chk("ch6 sweep count", n_fail, n_fail);
        chk("ch6 err_flags", err_flags6, 0);

        // Randomised traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_addr    = 8'($urandom_range(0, 199));
            wr_data    = 8'($urandom);
            wr_commit  = ($urandom_range(0, 9) == 0);
            rd_en      = ($urandom_range(0, 1) == 1);
            rd_addr    = 8'($urandom_range(0, 199));
            rd_release = ($urandom_range(0, 9) == 0);
            err_clr    = ($urandom_range(0, 19) == 0);
            model_step();
            tick();
            if (occupancy !== 2'(m_occ) || wr_ready !== (m_occ != 2) ||
                rd_avail !== (m_occ != 0) || err_flags !== m_err) begin
                chk($sformatf("rnd%0d state", c),
                    {occupancy, wr_ready, rd_avail, err_flags},
                    {2'(m_occ), m_occ != 2, m_occ != 0, m_err});
            end else begin
                n_chk++;
            end
            chk($sformatf("rnd%0d valid", c), rd_data_valid, (LAT == 1) ? m_v1 : m_v2);
            if ((LAT == 1) ? m_k1 : m_k2)
                chk($sformatf("rnd%0d data", c), rd_data, (LAT == 1) ? m_d1 : m_d2);
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
